// File: rtl/trng_word_scheduler.sv
// rtl/trng_word_scheduler.sv - TRNG sampler sequencer with word FIFO, round-robin serving and fault policy
module trng_word_scheduler #(
  parameter int WARMUP_CYCLES  = 1024,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ctrl_en,
  input  logic                        health_fail,
  input  logic                        fault_clear,
  output logic                        osc_enable,
  output logic                        sample_trig,
  output logic                        sampler_clear,
  input  logic [31:0]                 rand_word,
  input  logic [31:0]                 rand_count,
  input  logic [1:0]                  req,
  output logic [1:0]                  rsp_valid,
  output logic [31:0]                 rsp_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [2:0]                  state,
  output logic                        fault,
  output logic [1:0]                  fault_cause
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (WARMUP_CYCLES > TIMEOUT_CYCLES) ? WARMUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  // WARMUP lasts one cycle less than WARMUP_CYCLES so that ARM completes the osc_enable hold time.
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 2);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ARM    = 3'd2,
    S_TRIG   = 3'd3,
    S_WAIT   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   prev_q, prev_d;
  logic          have_prev_q, have_prev_d;
  logic [1:0]    cause_q, cause_d;
  logic          osc_q, osc_d;
  logic          trig_q, trig_d;
  logic          sclr_q, sclr_d;
  logic          fault_q, fault_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          last_q, last_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic push, pop, serve_ok, gnt_idx, sampling, fault_entry;

  assign sampling = (state_q == S_WARMUP) || (state_q == S_ARM) ||
                    (state_q == S_TRIG) || (state_q == S_WAIT);
  assign serve_ok = (state_q != S_FAULT) && (level_q != '0) && (req != 2'b00);
  assign gnt_idx  = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    cause_d     = cause_q;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_en) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
        end
      end
      S_WARMUP: begin
        if (cnt_q == WARM_LAST) state_d = S_ARM;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      S_ARM: begin
        if ((level_q < DEPTH_L) || serve_ok) state_d = S_TRIG;
      end
      S_TRIG: begin
        base_d  = rand_count;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rand_count != base_q) begin
          if (have_prev_q && (rand_word == prev_q)) begin
            state_d = S_FAULT;
            cause_d = 2'd3;
          end else begin
            push        = 1'b1;
            prev_d      = rand_word;
            have_prev_d = 1'b1;
            state_d     = S_ARM;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAULT;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d     = S_IDLE;
          cause_d     = 2'd0;
          have_prev_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A health failure beats capture faults; dropping ctrl_en abandons any capture in flight.
    if (sampling && health_fail) begin
      state_d     = S_FAULT;
      cause_d     = 2'd1;
      push        = 1'b0;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
    end else if (!ctrl_en && (state_q != S_FAULT) && (state_d != S_FAULT)) begin
      state_d     = S_IDLE;
      push        = 1'b0;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
    end
  end

  always_comb begin
    pop         = serve_ok && (state_d != S_FAULT);
    fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (fault_entry) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = rand_word;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end

    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    last_d      = last_q;
    if (pop) begin
      rsp_valid_d = gnt_idx ? 2'b10 : 2'b01;
      rsp_data_d  = mem_q[rd_ptr_q];
      last_d      = gnt_idx;
    end

    osc_d   = (state_d == S_WARMUP) || (state_d == S_ARM) ||
              (state_d == S_TRIG) || (state_d == S_WAIT);
    trig_d  = (state_d == S_TRIG);
    sclr_d  = (state_q == S_FAULT) && (state_d == S_IDLE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      cause_q     <= 2'd0;
      osc_q       <= 1'b0;
      trig_q      <= 1'b0;
      sclr_q      <= 1'b0;
      fault_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      last_q      <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      cause_q     <= cause_d;
      osc_q       <= osc_d;
      trig_q      <= trig_d;
      sclr_q      <= sclr_d;
      fault_q     <= fault_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign osc_enable    = osc_q;
  assign sample_trig   = trig_q;
  assign sampler_clear = sclr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign fifo_level    = level_q;
  assign state         = state_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;

endmodule
